// File: rtl/painterengine_gpu_pkg.sv
// Shared types and constants for the multi-channel GPU write DMA.
// State encoding, error codes and fixed AXI field values.
package painterengine_gpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_CALC,
    S_AW,
    S_W,
    S_B
  } state_t;

  localparam logic [2:0] ERR_OK     = 3'd0;
  localparam logic [2:0] ERR_ADDR   = 3'd2;
  localparam logic [2:0] ERR_RESP   = 3'd3;
  localparam logic [2:0] ERR_WB_TMO = 3'd4;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_VAL  = 4'b0010;
  localparam int         PAGE_BYTES     = 4096;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/painterengine_gpu_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index.
// Pointer moves past the winner whenever a grant is taken.
module painterengine_gpu_rr_arbiter
  import painterengine_gpu_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_w(N)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_adv,
  output logic          o_valid,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_c;
  int            w_sum;

  // Scan from the far end so the closest request to r_ptr wins.
  always_comb begin
    o_valid = 1'b0;
    o_gnt   = '0;
    o_idx   = '0;
    w_sum   = 0;
    w_c     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = int'(r_ptr) + k;
      if (w_sum >= N) w_sum = w_sum - N;
      w_c = IW'(w_sum);
      if (i_req[w_c]) begin
        o_valid  = 1'b1;
        o_gnt    = '0;
        o_gnt[w_c] = 1'b1;
        o_idx    = w_c;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_adv && o_valid) begin
      r_ptr <= (o_idx == IW'(N - 1)) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/painterengine_gpu_dma_writer_mc.sv
// Multi-channel AXI4 write DMA, round-robin job arbitration, 4 KB safe bursts.
// Optional stall timeout: define PAINTERENGINE_GPU_WRITER_TIMEOUT_EN.
module painterengine_gpu_dma_writer_mc
  import painterengine_gpu_pkg::*;
#(
  parameter int PARAM_CHANNELS     = 4,
  parameter int PARAM_DATA_WIDTH   = 32,
  parameter int PARAM_MAX_BURST    = 16,
  parameter int PARAM_TIMEOUT_BITS = 16
) (
  input  logic                                 i_wire_clock,
  input  logic                                 i_wire_resetn,
  input  logic [PARAM_CHANNELS-1:0]            i_wire_start,
  input  logic [32*PARAM_CHANNELS-1:0]         i_wire_address,
  input  logic [32*PARAM_CHANNELS-1:0]         i_wire_length,
  input  logic [PARAM_DATA_WIDTH*PARAM_CHANNELS-1:0] i_wire_data,
  input  logic [PARAM_CHANNELS-1:0]            i_wire_data_valid,
  output logic [PARAM_CHANNELS-1:0]            o_wire_data_next,
  output logic                                 o_wire_busy,
  output logic [PARAM_CHANNELS-1:0]            o_wire_done,
  output logic [PARAM_CHANNELS-1:0]            o_wire_error,
  output logic [3*PARAM_CHANNELS-1:0]          o_wire_error_type,
  output logic [0:0]                           o_wire_M_AXI_AWID,
  output logic [31:0]                          o_wire_M_AXI_AWADDR,
  output logic [7:0]                           o_wire_M_AXI_AWLEN,
  output logic [2:0]                           o_wire_M_AXI_AWSIZE,
  output logic [1:0]                           o_wire_M_AXI_AWBURST,
  output logic                                 o_wire_M_AXI_AWLOCK,
  output logic [3:0]                           o_wire_M_AXI_AWCACHE,
  output logic [2:0]                           o_wire_M_AXI_AWPROT,
  output logic [3:0]                           o_wire_M_AXI_AWQOS,
  output logic                                 o_wire_M_AXI_AWVALID,
  input  logic                                 i_wire_M_AXI_AWREADY,
  output logic [PARAM_DATA_WIDTH-1:0]          o_wire_M_AXI_WDATA,
  output logic [PARAM_DATA_WIDTH/8-1:0]        o_wire_M_AXI_WSTRB,
  output logic                                 o_wire_M_AXI_WLAST,
  output logic                                 o_wire_M_AXI_WVALID,
  input  logic                                 i_wire_M_AXI_WREADY,
  input  logic [0:0]                           i_wire_M_AXI_BID,
  input  logic [1:0]                           i_wire_M_AXI_BRESP,
  input  logic                                 i_wire_M_AXI_BVALID,
  output logic                                 o_wire_M_AXI_BREADY
);

  localparam int C  = PARAM_CHANNELS;
  localparam int DW = PARAM_DATA_WIDTH;
  localparam int SZ = $clog2(DW / 8);
  localparam int CW = idx_w(C);

  state_t           r_state;
  logic [CW-1:0]    r_gnt;
  logic [31:0]      r_base, r_length, r_offset;
  logic [31:0]      r_awaddr;
  logic [7:0]       r_awlen;
  logic [8:0]       r_len, r_beat;
  logic             r_awvalid;
  logic [C-1:0]     r_done, r_err;
  logic [2:0]       r_etype [C];

  logic [31:0]      w_addr [C];
  logic [31:0]      w_length [C];
  logic [DW-1:0]    w_data [C];
  logic [C-1:0]     w_req, w_arb_gnt;
  logic [CW-1:0]    w_arb_idx;
  logic             w_arb_valid;
  logic [31:0]      w_baddr, w_rem, w_page, w_len;
  logic             w_wvalid, w_wlast, w_whs;
  logic             w_unused;

  always_comb begin
    for (int c = 0; c < C; c++) begin
      w_addr[c]   = i_wire_address[c*32 +: 32];
      w_length[c] = i_wire_length[c*32 +: 32];
      w_data[c]   = i_wire_data[c*DW +: DW];
      o_wire_error_type[c*3 +: 3] = r_etype[c];
    end
  end

  assign w_req = i_wire_start & ~r_done & ~r_err;

  painterengine_gpu_rr_arbiter #(.N(C)) u_arb (
    .i_clk   (i_wire_clock),
    .i_rst_n (i_wire_resetn),
    .i_req   (w_req),
    .i_adv   (r_state == S_IDLE),
    .o_valid (w_arb_valid),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx)
  );

  // Burst length: remaining beats, capped by max burst and the 4 KB page.
  always_comb begin
    w_baddr = r_base + (r_offset << SZ);
    w_rem   = r_length - r_offset;
    w_page  = (32'(PAGE_BYTES) - {20'd0, w_baddr[11:0]}) >> SZ;
    w_len   = w_rem;
    if (w_len > 32'(PARAM_MAX_BURST)) w_len = 32'(PARAM_MAX_BURST);
    if (w_len > w_page) w_len = w_page;
  end

  assign w_wvalid = (r_state == S_W) && i_wire_data_valid[r_gnt];
  assign w_wlast  = (r_state == S_W) && (r_beat == r_len - 9'd1);
  assign w_whs    = w_wvalid && i_wire_M_AXI_WREADY;

  always_comb begin
    o_wire_data_next = '0;
    if (w_whs) o_wire_data_next[r_gnt] = 1'b1;
  end

`ifdef PAINTERENGINE_GPU_WRITER_TIMEOUT_EN
  logic [PARAM_TIMEOUT_BITS-1:0] r_tmo;
  logic [PARAM_TIMEOUT_BITS-1:0] w_tmo_nxt;
  logic w_wait, w_hs;
  assign w_tmo_nxt = r_tmo + 1'b1;
  assign w_wait = (r_state == S_AW) || (r_state == S_W) ||
                  (r_state == S_B);
  assign w_hs = (r_state == S_AW && r_awvalid && i_wire_M_AXI_AWREADY) ||
                w_whs ||
                (r_state == S_B && i_wire_M_AXI_BVALID);
`else
  logic [PARAM_TIMEOUT_BITS-1:0] w_unused_tmo;
  assign w_unused_tmo = '0;
`endif

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_base    <= '0;
      r_length  <= '0;
      r_offset  <= '0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_awvalid <= 1'b0;
      r_done    <= '0;
      r_err     <= '0;
      for (int c = 0; c < C; c++) r_etype[c] <= ERR_OK;
`ifdef PAINTERENGINE_GPU_WRITER_TIMEOUT_EN
      r_tmo     <= '0;
`endif
    end else begin
      for (int c = 0; c < C; c++) begin
        if (!i_wire_start[c] &&
            !(r_state != S_IDLE && r_gnt == CW'(c))) begin
          r_done[c]  <= 1'b0;
          r_err[c]   <= 1'b0;
          r_etype[c] <= ERR_OK;
        end
      end
      unique case (r_state)
        S_IDLE: if (w_arb_valid) begin
          r_gnt    <= w_arb_idx;
          r_base   <= w_addr[w_arb_idx];
          r_length <= w_length[w_arb_idx];
          r_state  <= S_CHECK;
        end
        S_CHECK: begin
          if (r_base[SZ-1:0] != '0 || r_length == '0) begin
            r_err[r_gnt]   <= 1'b1;
            r_etype[r_gnt] <= ERR_ADDR;
            r_state        <= S_IDLE;
          end else begin
            r_offset <= '0;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_awaddr <= w_baddr;
          r_len    <= w_len[8:0];
          r_awlen  <= w_len[7:0] - 8'd1;
          r_beat   <= '0;
          r_state  <= S_AW;
        end
        S_AW: begin
          if (!r_awvalid) begin
            r_awvalid <= 1'b1;
          end else if (i_wire_M_AXI_AWREADY) begin
            r_awvalid <= 1'b0;
            r_state   <= S_W;
          end
        end
        S_W: if (w_whs) begin
          r_beat <= r_beat + 9'd1;
          if (w_wlast) begin
            r_offset <= r_offset + {23'd0, r_len};
            r_state  <= S_B;
          end
        end
        S_B: if (i_wire_M_AXI_BVALID) begin
          if (i_wire_M_AXI_BRESP[1]) begin
            r_err[r_gnt]   <= 1'b1;
            r_etype[r_gnt] <= ERR_RESP;
            r_state        <= S_IDLE;
          end else if (r_offset == r_length) begin
            r_done[r_gnt] <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_state <= S_CALC;
          end
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef PAINTERENGINE_GPU_WRITER_TIMEOUT_EN
      if (!w_wait || w_hs) begin
        r_tmo <= '0;
      end else if (&w_tmo_nxt) begin
        r_tmo          <= '0;
        r_awvalid      <= 1'b0;
        r_state        <= S_IDLE;
        r_err[r_gnt]   <= 1'b1;
        r_etype[r_gnt] <= (r_state == S_AW) ? ERR_RESP : ERR_WB_TMO;
      end else begin
        r_tmo <= w_tmo_nxt;
      end
`endif
    end
  end

  assign o_wire_busy          = (r_state != S_IDLE);
  assign o_wire_done          = r_done;
  assign o_wire_error         = r_err;
  assign o_wire_M_AXI_AWID    = 1'b0;
  assign o_wire_M_AXI_AWADDR  = r_awaddr;
  assign o_wire_M_AXI_AWLEN   = r_awlen;
  assign o_wire_M_AXI_AWSIZE  = 3'(SZ);
  assign o_wire_M_AXI_AWBURST = AXI_BURST_INCR;
  assign o_wire_M_AXI_AWLOCK  = 1'b0;
  assign o_wire_M_AXI_AWCACHE = AXI_CACHE_VAL;
  assign o_wire_M_AXI_AWPROT  = 3'd0;
  assign o_wire_M_AXI_AWQOS   = 4'd0;
  assign o_wire_M_AXI_AWVALID = r_awvalid;
  assign o_wire_M_AXI_WDATA   = (r_state == S_W) ? w_data[r_gnt] : '0;
  assign o_wire_M_AXI_WSTRB   = '1;
  assign o_wire_M_AXI_WLAST   = w_wlast;
  assign o_wire_M_AXI_WVALID  = w_wvalid;
  assign o_wire_M_AXI_BREADY  = (r_state == S_B);

  assign w_unused = ^{i_wire_M_AXI_BID, i_wire_M_AXI_BRESP[0],
                      w_len[31:9], w_arb_gnt};

endmodule

// File: tb/tb_painterengine_gpu_dma_writer_mc.sv
// Directed bench for the multi-channel write DMA with a small AXI slave.
// Covers bursts, 4 KB split, errors, round-robin and reset.
module tb_painterengine_gpu_dma_writer_mc;

  localparam int C  = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [C-1:0]      start, dvalid, dnext, done, error;
  logic [32*C-1:0]   addr_bus, len_bus;
  logic [DW*C-1:0]   data_bus;
  logic [3*C-1:0]    etype;
  logic              busy;
  logic [0:0]        awid, bid;
  logic [31:0]       awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize, awprot;
  logic [1:0]        awburst, bresp;
  logic              awlock, awvalid, awready;
  logic [3:0]        awcache, awqos;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wstrb;
  logic              wlast, wvalid, wready;
  logic              bvalid, bready;

  int errs = 0;
  int checks = 0;

  logic [31:0] aw_addr_q [$];
  logic [7:0]  aw_len_q [$];
  int          beats_q [$];
  logic [1:0]  resp_q [$];
  int          cur_beats;
  logic [31:0] last_wdata;
  logic [15:0] cnt [C];

  always_comb begin
    for (int c = 0; c < C; c++)
      data_bus[c*DW +: DW] = {16'(c), cnt[c]};
  end

  painterengine_gpu_dma_writer_mc #(
    .PARAM_CHANNELS(C), .PARAM_DATA_WIDTH(DW),
    .PARAM_MAX_BURST(16), .PARAM_TIMEOUT_BITS(4)
  ) dut (
    .i_wire_clock(clk), .i_wire_resetn(rst_n),
    .i_wire_start(start), .i_wire_address(addr_bus),
    .i_wire_length(len_bus), .i_wire_data(data_bus),
    .i_wire_data_valid(dvalid), .o_wire_data_next(dnext),
    .o_wire_busy(busy), .o_wire_done(done),
    .o_wire_error(error), .o_wire_error_type(etype),
    .o_wire_M_AXI_AWID(awid), .o_wire_M_AXI_AWADDR(awaddr),
    .o_wire_M_AXI_AWLEN(awlen), .o_wire_M_AXI_AWSIZE(awsize),
    .o_wire_M_AXI_AWBURST(awburst), .o_wire_M_AXI_AWLOCK(awlock),
    .o_wire_M_AXI_AWCACHE(awcache), .o_wire_M_AXI_AWPROT(awprot),
    .o_wire_M_AXI_AWQOS(awqos), .o_wire_M_AXI_AWVALID(awvalid),
    .i_wire_M_AXI_AWREADY(awready),
    .o_wire_M_AXI_WDATA(wdata), .o_wire_M_AXI_WSTRB(wstrb),
    .o_wire_M_AXI_WLAST(wlast), .o_wire_M_AXI_WVALID(wvalid),
    .i_wire_M_AXI_WREADY(wready),
    .i_wire_M_AXI_BID(bid), .i_wire_M_AXI_BRESP(bresp),
    .i_wire_M_AXI_BVALID(bvalid), .o_wire_M_AXI_BREADY(bready)
  );

  // Slave: sample handshakes at negedge, update inputs just after posedge.
  initial begin : slave
    logic hs_w, hs_b, lst;
    logic [C-1:0] dn;
    forever begin
      @(negedge clk);
      hs_w = wvalid && wready;
      hs_b = bvalid && bready;
      lst  = wlast;
      dn   = dnext;
      if (awvalid && awready) begin
        aw_addr_q.push_back(awaddr);
        aw_len_q.push_back(awlen);
      end
      if (hs_w) begin
        last_wdata = wdata;
        cur_beats++;
        if (lst) begin
          beats_q.push_back(cur_beats);
          cur_beats = 0;
        end
      end
      @(posedge clk);
      #1;
      for (int c = 0; c < C; c++) if (dn[c]) cnt[c]++;
      if (hs_b) bvalid = 1'b0;
      if (hs_w && lst) begin
        bvalid = 1'b1;
        bresp  = 2'b00;
        if (resp_q.size() > 0) bresp = resp_q.pop_front();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    aw_addr_q.delete();
    aw_len_q.delete();
    beats_q.delete();
    resp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = '0;
    bvalid = 1'b0;
    wready = 1'b1;
    repeat (2) step();
    for (int c = 0; c < C; c++) cnt[c] = '0;
    cur_beats = 0;
    clear_log();
    rst_n = 1'b1;
    step();
  endtask

  task automatic set_job(input int ch, input logic [31:0] a,
                         input logic [31:0] l);
    addr_bus[ch*32 +: 32] = a;
    len_bus[ch*32 +: 32]  = l;
  endtask

  task automatic wait_ch(input int ch, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done[ch] || error[ch]) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({awvalid, wvalid, wlast, bready, busy} !== 5'b0) begin
      errs++;
      $display("FAIL reset_ctl got=%b want=00000",
               {awvalid, wvalid, wlast, bready, busy});
    end
    checks++;
    if ({done, error, etype, dnext} !== '0) begin
      errs++;
      $display("FAIL reset_status got=%h want=0",
               {done, error, etype, dnext});
    end
    checks++;
    if ({awsize, awburst, awcache, wstrb, awid, awlock, awprot, awqos}
        !== {3'd2, 2'b01, 4'b0010, 4'hf, 1'b0, 1'b0, 3'd0, 4'd0}) begin
      errs++;
      $display("FAIL reset_const size=%0d burst=%0d cache=%0d strb=%h",
               awsize, awburst, awcache, wstrb);
    end
  endtask

  task automatic test_two_bursts();
    bit ok;
    clear_log();
    set_job(0, 32'h1000, 32'd20);
    start[0] = 1'b1;
    repeat (3) step();
    checks++;
    if (awvalid !== 1'b0) begin
      errs++;
      $display("FAIL lat_early awvalid=%b want=0", awvalid);
    end
    step();
    checks++;
    if (awvalid !== 1'b1) begin
      errs++;
      $display("FAIL lat_n3 awvalid=%b want=1", awvalid);
    end
    wait_ch(0, ok);
    checks++;
    if (!ok || done[0] !== 1'b1 || error[0] !== 1'b0) begin
      errs++;
      $display("FAIL burst_done done=%b err=%b want 1/0", done[0], error[0]);
    end
    checks++;
    if (aw_addr_q.size() != 2 || beats_q.size() != 2) begin
      errs++;
      $display("FAIL burst_count aw=%0d w=%0d want=2/2",
               aw_addr_q.size(), beats_q.size());
    end else begin
      checks++;
      if (aw_addr_q[0] !== 32'h1000 || aw_len_q[0] !== 8'd15 ||
          aw_addr_q[1] !== 32'h1040 || aw_len_q[1] !== 8'd3) begin
        errs++;
        $display("FAIL burst_aw got=%h/%0d %h/%0d want=1000/15 1040/3",
                 aw_addr_q[0], aw_len_q[0], aw_addr_q[1], aw_len_q[1]);
      end
      checks++;
      if (beats_q[0] != 16 || beats_q[1] != 4) begin
        errs++;
        $display("FAIL burst_wlast got=%0d,%0d want=16,4",
                 beats_q[0], beats_q[1]);
      end
    end
    checks++;
    if (cnt[0] !== 16'd20 || last_wdata !== 32'h0000_0013) begin
      errs++;
      $display("FAIL burst_data next=%0d last=%h want=20/00000013",
               cnt[0], last_wdata);
    end
    start[0] = 1'b0;
    repeat (2) step();
    checks++;
    if (done[0] !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL done_clear done=%b busy=%b want=0/0", done[0], busy);
    end
  endtask

  task automatic test_boundary();
    bit ok;
    clear_log();
    set_job(2, 32'h0FF8, 32'd8);
    start[2] = 1'b1;
    wait_ch(2, ok);
    checks++;
    if (!ok || done[2] !== 1'b1 || aw_addr_q.size() != 2) begin
      errs++;
      $display("FAIL split_done done=%b aw=%0d want=1/2",
               done[2], aw_addr_q.size());
    end else begin
      checks++;
      if (aw_addr_q[0] !== 32'h0FF8 || aw_len_q[0] !== 8'd1 ||
          aw_addr_q[1] !== 32'h1000 || aw_len_q[1] !== 8'd5) begin
        errs++;
        $display("FAIL split_aw got=%h/%0d %h/%0d want=0ff8/1 1000/5",
                 aw_addr_q[0], aw_len_q[0], aw_addr_q[1], aw_len_q[1]);
      end
    end
    start[2] = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_addr_error();
    bit ok;
    clear_log();
    set_job(1, 32'h1002, 32'd4);
    start[1] = 1'b1;
    wait_ch(1, ok);
    checks++;
    if (!ok || error[1] !== 1'b1 || etype[5:3] !== 3'd2 ||
        done[1] !== 1'b0) begin
      errs++;
      $display("FAIL misalign err=%b type=%0d done=%b want=1/2/0",
               error[1], etype[5:3], done[1]);
    end
    start[1] = 1'b0;
    repeat (2) step();
    checks++;
    if (error[1] !== 1'b0 || etype[5:3] !== 3'd0) begin
      errs++;
      $display("FAIL err_clear err=%b type=%0d want=0/0",
               error[1], etype[5:3]);
    end
    set_job(1, 32'h2000, 32'd0);
    start[1] = 1'b1;
    wait_ch(1, ok);
    checks++;
    if (!ok || error[1] !== 1'b1 || etype[5:3] !== 3'd2) begin
      errs++;
      $display("FAIL zero_len err=%b type=%0d want=1/2",
               error[1], etype[5:3]);
    end
    checks++;
    if (aw_addr_q.size() != 0) begin
      errs++;
      $display("FAIL err_no_aw aw=%0d want=0", aw_addr_q.size());
    end
    start[1] = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_round_robin();
    int n;
    do_reset();
    for (int c = 0; c < C; c++) set_job(c, 32'h3000 + c * 32'h100, 32'd1);
    start = 4'hf;
    n = 0;
    while (done !== 4'hf && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (done !== 4'hf || aw_addr_q.size() != 4) begin
      errs++;
      $display("FAIL rr_done done=%b aw=%0d want=1111/4",
               done, aw_addr_q.size());
    end else begin
      checks++;
      if (aw_addr_q[0] !== 32'h3000 || aw_addr_q[1] !== 32'h3100 ||
          aw_addr_q[2] !== 32'h3200 || aw_addr_q[3] !== 32'h3300) begin
        errs++;
        $display("FAIL rr_order got=%h %h %h %h want=3000..3300",
                 aw_addr_q[0], aw_addr_q[1], aw_addr_q[2], aw_addr_q[3]);
      end
    end
    start = '0;
    repeat (2) step();
    clear_log();
    set_job(1, 32'h3800, 32'd1);
    start[1] = 1'b1;
    n = 0;
    while (done[1] !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    start[1] = 1'b0;
    repeat (2) step();
    clear_log();
    start = 4'b1001;
    n = 0;
    while ((done & 4'b1001) !== 4'b1001 && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (aw_addr_q.size() != 2) begin
      errs++;
      $display("FAIL rr_ptr_count aw=%0d want=2", aw_addr_q.size());
    end else begin
      checks++;
      if (aw_addr_q[0] !== 32'h3300 || aw_addr_q[1] !== 32'h3000) begin
        errs++;
        $display("FAIL rr_ptr_order got=%h %h want=3300 3000",
                 aw_addr_q[0], aw_addr_q[1]);
      end
    end
    start = '0;
    repeat (2) step();
  endtask

  task automatic test_bresp();
    bit ok;
    clear_log();
    resp_q.push_back(2'b10);
    set_job(0, 32'h4000, 32'd20);
    start[0] = 1'b1;
    wait_ch(0, ok);
    checks++;
    if (!ok || error[0] !== 1'b1 || etype[2:0] !== 3'd3 ||
        done[0] !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL bresp err=%b type=%0d done=%b busy=%b want=1/3/0/0",
               error[0], etype[2:0], done[0], busy);
    end
    checks++;
    if (aw_addr_q.size() != 1) begin
      errs++;
      $display("FAIL bresp_aw aw=%0d want=1", aw_addr_q.size());
    end
    set_job(2, 32'h5000, 32'd2);
    start[2] = 1'b1;
    wait_ch(2, ok);
    checks++;
    if (!ok || done[2] !== 1'b1 || aw_addr_q.size() != 2) begin
      errs++;
      $display("FAIL after_err done=%b aw=%0d want=1/2",
               done[2], aw_addr_q.size());
    end else begin
      checks++;
      if (aw_addr_q[1] !== 32'h5000 || aw_len_q[1] !== 8'd1 ||
          error[0] !== 1'b1) begin
        errs++;
        $display("FAIL after_err_aw got=%h/%0d err0=%b want=5000/1/1",
                 aw_addr_q[1], aw_len_q[1], error[0]);
      end
    end
    start = '0;
    repeat (2) step();
  endtask

`ifdef PAINTERENGINE_GPU_WRITER_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    do_reset();
    wready = 1'b0;
    set_job(1, 32'h7000, 32'd4);
    start[1] = 1'b1;
    wait_ch(1, ok);
    checks++;
    if (!ok || error[1] !== 1'b1 || etype[5:3] !== 3'd4 ||
        cnt[1] !== 16'd0) begin
      errs++;
      $display("FAIL timeout err=%b type=%0d beats=%0d want=1/4/0",
               error[1], etype[5:3], cnt[1]);
    end
    wready = 1'b1;
    start = '0;
    repeat (2) step();
  endtask
`endif

  task automatic test_reset_mid_w();
    int n;
    wready = 1'b0;
    set_job(3, 32'h6000, 32'd4);
    start[3] = 1'b1;
    n = 0;
    while (wvalid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (wvalid !== 1'b1) begin
      errs++;
      $display("FAIL midw_reach wvalid=%b want=1", wvalid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({awvalid, wvalid, wlast, bready, busy, dnext, done, error,
         etype, awaddr, awlen, wdata} !== '0) begin
      errs++;
      $display("FAIL midw_reset aw=%b w=%b b=%b busy=%b addr=%h want=0",
               awvalid, wvalid, bready, busy, awaddr);
    end
    step();
    start = '0;
    wready = 1'b1;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    start = '0;
    dvalid = '1;
    addr_bus = '0;
    len_bus = '0;
    awready = 1'b1;
    wready = 1'b1;
    bvalid = 1'b0;
    bresp = 2'b00;
    bid = 1'b0;
    cur_beats = 0;
    for (int c = 0; c < C; c++) cnt[c] = '0;
    test_reset();
    test_two_bursts();
    test_boundary();
    test_addr_error();
    test_round_robin();
    test_bresp();
`ifdef PAINTERENGINE_GPU_WRITER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_w();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
